hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the hold and flush controls of the F/D, D/E, E/M and M/W stage registers.
- Resolves three conditions: load-use hazards; taken branches resolved in EX; multi-cycle data-memory accesses in M, guarded by a watchdog.
- Also maintains stall and flush performance counters.

Parameters:
- TIMEOUT, 16: maximum freeze cycles for one M-stage memory access before forced release.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- id_rs1  in  5  source register 1 of the instruction in D.
- id_rs2  in  5  source register 2 of the instruction in D.
- id_rs1_used  in  1  the D instruction reads rs1.
- id_rs2_used  in  1  the D instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in E.
- ex_is_load  in  1  the instruction in E is a load.
- ex_branch_taken  in  1  branch/jump in E redirects the PC.
- mem_req  in  1  the instruction in M accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- err_clr  in  1  clears mem_err.
- stall_f  out  1  hold PC / F register.
- stall_d  out  1  hold D register.
- stall_e  out  1  hold E register.
- stall_m  out  1  hold M register.
- flush_d  out  1  load a bubble into D.
- flush_e  out  1  load a bubble into E.
- flush_w  out  1  load a bubble into W.
- mem_err  out  1  sticky: watchdog fired.
- stall_cnt  out  CNT_W  cycles with any stall asserted.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- State machine: IDLE, MEM_WAIT. wait_cnt is a counter of width clog2(TIMEOUT+1).
- freeze = mem_req & ~dmem_ready & ~wd_fire.
  - wd_fire = (state==MEM_WAIT) & (wait_cnt==TIMEOUT).
- IDLE → MEM_WAIT when freeze; wait_cnt <= 1.
- In MEM_WAIT:
  - If dmem_ready or wd_fire: → IDLE, wait_cnt <= 0.
  - Otherwise wait_cnt increments.
- Freeze outputs (combinational): freeze ⇒ stall_f, stall_d, stall_e, stall_m = 1 and flush_w = 1. All other controls are 0.
- Load-use (loaduse):
  - Condition: ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - When loaduse & ~freeze & ~ex_branch_taken: stall_f = stall_d = 1 and flush_e = 1.
- Taken branch: when ex_branch_taken & ~freeze, flush_d = flush_e = 1 and no stalls. The branch overrides load-use.
- Priority: freeze > branch > load-use.
  - Under freeze, the branch/load-use instruction stays held in E; its action is taken on the release cycle.
- wd_fire cycle:
  - freeze is deasserted, so the pipeline advances.
  - mem_err <= 1; it stays set until err_clr or reset.
  - err_clr and wd_fire in the same cycle: set wins.
- Counters:
  - stall_cnt increments in any cycle with stall_f|stall_m.
  - flush_cnt increments in any cycle with flush_d.
  - Both wrap at 2^CNT_W.
- Reset: rst low asynchronously forces state=IDLE, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0. While rst is low, all stall/flush outputs are 0.
  - Reset during MEM_WAIT abandons the wait; there is no error.
- The block holds no pipeline data; the stage registers remain responsible for their own contents.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 → one cycle stall_f=stall_d=flush_e=1; stall_cnt=1. Same stimulus with ex_rd=0 → no stall.
- Branch with load-use: ex_branch_taken=1 with hazard present → flush_d=flush_e=1, stall_f=0; flush_cnt=1.
- Memory wait: mem_req=1, dmem_ready low for 3 cycles then high → freeze outputs for exactly 3 cycles. State returns to IDLE on the ready cycle; stall_cnt=3.
- Watchdog: TIMEOUT=16, dmem_ready never asserted → freeze for 16 cycles, released on cycle 17, mem_err=1. err_clr pulse → mem_err=0.
- Simultaneous events: freeze with ex_branch_taken=1 → flush_d=0 while frozen; flush_d=1 on the release cycle.
- Reset: rst low mid-MEM_WAIT (cycle 2) → outputs 0 immediately, counters 0. After release, mem_req=0 → no stalls.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller covering load-use, taken branches and memory waits.
// A watchdog releases a stuck memory access, and two counters track stall cycles and branch flushes.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             err_clr,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             wd_fire, freeze, loaduse, br, lu;

    assign wd_fire = (state_q == MEM_WAIT) && (wait_q == WW'(TIMEOUT));
    // Gating with rst keeps every control low while reset is held.
    assign freeze  = rst & mem_req & ~dmem_ready & ~wd_fire;
    assign loaduse = ex_is_load & (ex_rd != 5'd0) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    assign br      = rst & ex_branch_taken & ~freeze;
    assign lu      = rst & loaduse & ~freeze & ~ex_branch_taken;

    assign stall_f   = freeze | lu;
    assign stall_d   = freeze | lu;
    assign stall_e   = freeze;
    assign stall_m   = freeze;
    assign flush_d   = br;
    assign flush_e   = br | lu;
    assign flush_w   = freeze;
    assign mem_err   = err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        if (state_q == IDLE) begin
            if (freeze) begin
                state_d = MEM_WAIT;
                wait_d  = WW'(1);
            end
        end else if (dmem_ready || wd_fire) begin
            state_d = IDLE;
            wait_d  = '0;
        end else begin
            wait_d  = wait_q + 1'b1;
        end
        err_d       = wd_fire ? 1'b1 : (err_clr ? 1'b0 : err_q);
        stall_cnt_d = (stall_f | stall_m) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = flush_d ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule
